// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// State encodings and widths used by dmem_ctrl and dmem_wait_cnt.
package dmem_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        DMEM_IDLE   = 2'd0,
        DMEM_ACCESS = 2'd1,
        DMEM_DONE   = 2'd2
    } dmem_state_e;

    // Bits needed to hold 0..max (at least one bit).
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Saturating up-counter with synchronous clear.
// sat_o is high once the count has reached MAX.
module dmem_wait_cnt
    import dmem_ctrl_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic sat_o
);

    localparam int W = cnt_w(MAX);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over count; stop at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: latches a mem-stage request, runs the
// SRAM access with wait states, stalls the pipe. Option: DMEM_TIMEOUT_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = ADDR_WIDTH,
    parameter int DATA_W         = DATA_WIDTH,
    parameter int WAIT_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              sram_ce_o,
    output logic              sram_oe_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    input  logic              sram_ready_i
);

    dmem_state_e       state_q;
    dmem_state_e       state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic start;
    logic in_access;
    logic wait_sat;
    logic done_ok;
    logic timeout;
    logic addr_lsb_unused;

    assign start     = (state_q == DMEM_IDLE) && ce_i;
    assign in_access = (state_q == DMEM_ACCESS);
    assign done_ok   = in_access && wait_sat && sram_ready_i;

    // Byte offset is dropped; the SRAM is word addressed.
    assign addr_lsb_unused = ^addr_i[1:0];

    dmem_wait_cnt #(
        .MAX(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(start),
        .en_i (in_access),
        .sat_o(wait_sat)
    );

`ifdef DMEM_TIMEOUT_EN
    logic to_sat;

    dmem_wait_cnt #(
        .MAX(TIMEOUT_CYCLES - 1)
    ) u_to_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(start),
        .en_i (in_access),
        .sat_o(to_sat)
    );

    assign timeout = in_access && !done_ok && to_sat;
`else
    logic to_unused;

    assign to_unused = (TIMEOUT_CYCLES != 0);
    assign timeout   = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DMEM_IDLE:   if (ce_i) state_d = DMEM_ACCESS;
            DMEM_ACCESS: if (done_ok || timeout) state_d = DMEM_DONE;
            DMEM_DONE:   state_d = DMEM_IDLE;
            default:     state_d = DMEM_IDLE;
        endcase
    end

    // State, latched request, read data and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DMEM_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= timeout;
            if (start) begin
                we_q    <= we_i;
                addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                wdata_q <= wdata_i;
            end
            if (done_ok && !we_q) begin
                rdata_q <= sram_rdata_i;
            end else if (timeout && !we_q) begin
                rdata_q <= '0;
            end
        end
    end

    // Stall: follows ce in IDLE, held through ACCESS, released in DONE.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            DMEM_IDLE:   stall_o = ce_i;
            DMEM_ACCESS: stall_o = 1'b1;
            DMEM_DONE:   stall_o = 1'b0;
            default:     stall_o = 1'b0;
        endcase
    end

    assign sram_ce_o    = in_access;
    assign sram_oe_o    = in_access && !we_q;
    assign sram_we_o    = in_access && we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two instances, WAIT_CYCLES 1 and 0.
// Timeout scenario is built when DMEM_TIMEOUT_EN is defined.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce1, ce0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] s_rdata;
    logic        s_ready;

    logic [31:0] rdata1, rdata0;
    logic        stall1, stall0, err1, err0;
    logic        sce1, sce0, soe1, soe0, swe1, swe0;
    logic [31:0] saddr1, saddr0, swd1, swd0;

    int errors = 0;
    int checks = 0;

    int          n_stall, n_ce, n_oe, n_we, n_err;
    logic [31:0] rd_done, seen_addr, seen_wd;
    logic        stall_at_err;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_W(32), .DATA_W(32),
        .WAIT_CYCLES(1), .TIMEOUT_CYCLES(8)
    ) u_w1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce1), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1),
        .stall_o(stall1), .err_o(err1),
        .sram_ce_o(sce1), .sram_oe_o(soe1), .sram_we_o(swe1),
        .sram_addr_o(saddr1), .sram_wdata_o(swd1),
        .sram_rdata_i(s_rdata), .sram_ready_i(s_ready)
    );

    dmem_ctrl #(
        .ADDR_W(32), .DATA_W(32),
        .WAIT_CYCLES(0), .TIMEOUT_CYCLES(8)
    ) u_w0 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce0), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata0),
        .stall_o(stall0), .err_o(err0),
        .sram_ce_o(sce0), .sram_oe_o(soe0), .sram_we_o(swe0),
        .sram_addr_o(saddr0), .sram_wdata_o(swd0),
        .sram_rdata_i(s_rdata), .sram_ready_i(s_ready)
    );

    // Entered just after a negedge; returns at the negedge after DONE.
    task automatic do_access(input bit sel, input bit w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] sram_val,
                             input int wt, input int low, input bit keep);
        int  lim;
        bit  fin;
        logic st, c, o, wr, e;
        lim = (low > 0) ? wt + low : 0;
        n_stall = 0; n_ce = 0; n_oe = 0; n_we = 0; n_err = 0;
        rd_done = 'x; seen_addr = 'x; seen_wd = 'x; stall_at_err = 1'bx;
        fin = 1'b0;
        we = w; addr = a; wdata = d;
        if (sel) ce1 = 1'b1; else ce0 = 1'b1;
        s_ready = (lim == 0);
        s_rdata = s_ready ? sram_val : 32'hDEAD_0000;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            #1;
            st = sel ? stall1 : stall0;
            c  = sel ? sce1 : sce0;
            o  = sel ? soe1 : soe0;
            wr = sel ? swe1 : swe0;
            e  = sel ? err1 : err0;
            if (st) n_stall++;
            if (o) n_oe++;
            if (wr) n_we++;
            if (e) begin
                n_err++;
                stall_at_err = st;
            end
            if (c) begin
                n_ce++;
                seen_addr = sel ? saddr1 : saddr0;
                seen_wd   = sel ? swd1 : swd0;
            end
            s_ready = !(c && (n_ce <= lim));
            s_rdata = s_ready ? sram_val : (32'hDEAD_0000 | n_ce);
            if (!st) begin
                fin = 1'b1;
                rd_done = sel ? rdata1 : rdata0;
                if (!keep) begin
                    ce1 = 1'b0;
                    ce0 = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!fin) begin
            $display("FAIL access_timeout: got no DONE expected DONE within 60 cycles");
            errors++;
            ce1 = 1'b0;
            ce0 = 1'b0;
        end
        checks++;
        // One more edge so a trailing err pulse is seen.
        #1;
        if ((sel ? err1 : err0) === 1'b1) n_err++;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce1 = 0; ce0 = 0; we = 0; addr = 0; wdata = 0;
        s_rdata = 0; s_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        if ({stall1, err1, sce1, soe1, swe1} !== 5'b0) begin
            $display("FAIL reset_strobes1: got %b expected 00000",
                     {stall1, err1, sce1, soe1, swe1});
            errors++;
        end
        checks++;
        if ({stall0, err0, sce0, soe0, swe0} !== 5'b0) begin
            $display("FAIL reset_strobes0: got %b expected 00000",
                     {stall0, err0, sce0, soe0, swe0});
            errors++;
        end
        checks++;
        if ({rdata1, saddr1, swd1} !== 96'h0) begin
            $display("FAIL reset_data1: got %h expected 0",
                     {rdata1, saddr1, swd1});
            errors++;
        end
        checks++;
        if ({rdata0, saddr0, swd0} !== 96'h0) begin
            $display("FAIL reset_data0: got %h expected 0",
                     {rdata0, saddr0, swd0});
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A5_1234, 1, 0, 1'b0);
        if (n_stall !== 3) begin
            $display("FAIL read_stall: got %0d expected 3", n_stall);
            errors++;
        end
        checks++;
        if (n_oe !== 2) begin
            $display("FAIL read_oe: got %0d expected 2", n_oe);
            errors++;
        end
        checks++;
        if (n_we !== 0) begin
            $display("FAIL read_we: got %0d expected 0", n_we);
            errors++;
        end
        checks++;
        if (rd_done !== 32'hA5A5_1234) begin
            $display("FAIL read_data: got %h expected a5a51234", rd_done);
            errors++;
        end
        checks++;
        if (seen_addr !== 32'h100) begin
            $display("FAIL read_addr: got %h expected 00000100", seen_addr);
            errors++;
        end
        checks++;
    endtask

    task automatic test_write_w0();
        do_access(1'b0, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
        if (n_stall !== 2 || rd_done !== 32'hCAFE_F00D) begin
            $display("FAIL w0_read: got stall=%0d data=%h expected 2 cafef00d",
                     n_stall, rd_done);
            errors++;
        end
        checks++;
        do_access(1'b0, 1'b1, 32'h104, 32'h1122_3344, 32'h5555_5555, 0, 0, 1'b0);
        if (n_we !== 1) begin
            $display("FAIL write_we: got %0d expected 1", n_we);
            errors++;
        end
        checks++;
        if (n_oe !== 0) begin
            $display("FAIL write_oe: got %0d expected 0", n_oe);
            errors++;
        end
        checks++;
        if (n_stall !== 2) begin
            $display("FAIL write_stall: got %0d expected 2", n_stall);
            errors++;
        end
        checks++;
        if (seen_wd !== 32'h1122_3344) begin
            $display("FAIL write_wdata: got %h expected 11223344", seen_wd);
            errors++;
        end
        checks++;
        if (seen_addr !== 32'h104) begin
            $display("FAIL write_addr: got %h expected 00000104", seen_addr);
            errors++;
        end
        checks++;
        if (rd_done !== 32'hCAFE_F00D) begin
            $display("FAIL write_rdata_hold: got %h expected cafef00d", rd_done);
            errors++;
        end
        checks++;
    endtask

    task automatic test_unaligned();
        do_access(1'b1, 1'b0, 32'h107, 32'h0, 32'h0BAD_F00D, 1, 0, 1'b0);
        if (seen_addr !== 32'h104) begin
            $display("FAIL unaligned_addr: got %h expected 00000104", seen_addr);
            errors++;
        end
        checks++;
    endtask

    task automatic test_ready_low();
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 32'h1357_9BDF, 1, 4, 1'b0);
        if (n_stall !== 7) begin
            $display("FAIL rdylow_stall: got %0d expected 7", n_stall);
            errors++;
        end
        checks++;
        if (n_oe !== 6) begin
            $display("FAIL rdylow_oe: got %0d expected 6", n_oe);
            errors++;
        end
        checks++;
        if (rd_done !== 32'h1357_9BDF) begin
            $display("FAIL rdylow_data: got %h expected 13579bdf", rd_done);
            errors++;
        end
        checks++;
        if (n_err !== 0) begin
            $display("FAIL rdylow_err: got %0d expected 0", n_err);
            errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 32'h400, 32'h0, 32'h0000_AAAA, 1, 0, 1'b1);
        if (rd_done !== 32'h0000_AAAA) begin
            $display("FAIL b2b_first: got %h expected 0000aaaa", rd_done);
            errors++;
        end
        checks++;
        do_access(1'b1, 1'b0, 32'h408, 32'h0, 32'h0000_BBBB, 1, 0, 1'b0);
        if (n_stall !== 3) begin
            $display("FAIL b2b_stall: got %0d expected 3", n_stall);
            errors++;
        end
        checks++;
        if (rd_done !== 32'h0000_BBBB || seen_addr !== 32'h408) begin
            $display("FAIL b2b_second: got %h@%h expected 0000bbbb@00000408",
                     rd_done, seen_addr);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        we = 1'b1; addr = 32'h500; wdata = 32'hFFFF_0000;
        s_ready = 1'b1; ce1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; ce1 = 1'b0;
        #1;
        if (swe1 !== 1'b1) begin
            $display("FAIL mid_in_access: got %b expected 1", swe1);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        if ({sce1, soe1, swe1, stall1, err1} !== 5'b0) begin
            $display("FAIL mid_strobes: got %b expected 00000",
                     {sce1, soe1, swe1, stall1, err1});
            errors++;
        end
        checks++;
        if ({rdata1, saddr1, swd1} !== 96'h0) begin
            $display("FAIL mid_regs: got %h expected 0", {rdata1, saddr1, swd1});
            errors++;
        end
        checks++;
        ce1 = 1'b1;
        #1;
        if (stall1 !== 1'b1) begin
            $display("FAIL mid_stall_follow: got %b expected 1", stall1);
            errors++;
        end
        checks++;
        ce1 = 1'b0;
        #1;
        if (stall1 !== 1'b0) begin
            $display("FAIL mid_stall_idle: got %b expected 0", stall1);
            errors++;
        end
        checks++;
        @(negedge clk);
        #1;
        if (sce1 !== 1'b0) begin
            $display("FAIL mid_no_reissue: got %b expected 0", sce1);
            errors++;
        end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
`ifdef DMEM_TIMEOUT_EN
        do_access(1'b1, 1'b0, 32'h600, 32'h0, 32'h7777_7777, 1, 100, 1'b0);
        if (n_ce !== 8) begin
            $display("FAIL to_access_cycles: got %0d expected 8", n_ce);
            errors++;
        end
        checks++;
        if (n_err !== 1) begin
            $display("FAIL to_err_pulses: got %0d expected 1", n_err);
            errors++;
        end
        checks++;
        if (rd_done !== 32'h0) begin
            $display("FAIL to_rdata: got %h expected 00000000", rd_done);
            errors++;
        end
        checks++;
        if (stall_at_err !== 1'b0) begin
            $display("FAIL to_stall_done: got %b expected 0", stall_at_err);
            errors++;
        end
        checks++;
`else
        do_access(1'b1, 1'b0, 32'h600, 32'h0, 32'h7777_7777, 1, 20, 1'b0);
        if (n_stall !== 23) begin
            $display("FAIL nto_stall: got %0d expected 23", n_stall);
            errors++;
        end
        checks++;
        if (n_err !== 0 || rd_done !== 32'h7777_7777) begin
            $display("FAIL nto_result: got err=%0d data=%h expected 0 77777777",
                     n_err, rd_done);
            errors++;
        end
        checks++;
`endif
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_w0();
        test_unaligned();
        test_ready_low();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the combinational `mem` stage and the external data SRAM. Latches each memory request issued by `mem`, drives the SRAM for a configurable number of wait states plus a ready handshake, and holds the pipeline via `stall_o` until the access finishes. Read data is registered and returned to `mem` for load extraction and store merging.

## Interface
- `ADDR_W`, 32: address width (`` `ADDR_WIDTH ``).
- `DATA_W`, 32: data width (`` `DATA_WIDTH ``).
- `WAIT_CYCLES`, 1: minimum SRAM wait states per access; 0 is legal.
- `TIMEOUT_CYCLES`, 64: ACCESS cycle limit; used only with `DMEM_TIMEOUT_EN`.
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `ce_i` in 1: request valid (from `mem` `ram_ce_o`).
- `we_i` in 1: 1 = write, 0 = read (from `ram_w_request_o`).
- `addr_i` in ADDR_W: byte address (from `ram_addr_o`).
- `wdata_i` in DATA_W: write word (from `ram_data_o`).
- `rdata_o` out DATA_W: registered read word (to `mem` `ram_data_i`).
- `stall_o` out 1: freeze IF..MEM and hold `exe_mem`/`mem` inputs.
- `err_o` out 1: one-cycle pulse on access timeout.
- `sram_ce_o`, `sram_oe_o`, `sram_we_o` out 1: SRAM strobes, active-high.
- `sram_addr_o` out ADDR_W: word address, `{addr[ADDR_W-1:2], 2'b00}`.
- `sram_wdata_o` out DATA_W: SRAM write data.
- `sram_rdata_i` in DATA_W: SRAM read data.
- `sram_ready_i` in 1: SRAM ready, sampled only in ACCESS.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: `stall_o = ce_i` (combinational). If `ce_i`, latch `we_i`, word-aligned `addr_i`, `wdata_i`; clear the wait counter; go to ACCESS.
- ACCESS: `stall_o` = 1. Strobes are driven from the latched request: `sram_ce_o` = 1, `sram_oe_o` = !we, `sram_we_o` = we. The counter increments and saturates at `WAIT_CYCLES`. When counter ≥ `WAIT_CYCLES` and `sram_ready_i` = 1: a read captures `sram_rdata_i` into `rdata_o`; either access type goes to DONE.
- DONE: `stall_o` = 0, strobes 0; the pipeline advances on this edge. Go to IDLE unconditionally. The held request is never reissued.
- `rdata_o` changes only on a read completion. Writes leave it unchanged.
- `ce_i` = 0 in IDLE: no SRAM activity, `stall_o` = 0.
- Request inputs that change during ACCESS are ignored; the latched copy is used.
- `rst_i` in any state, including mid-ACCESS: next state IDLE. Strobes, `stall_o`, `err_o`, `rdata_o`, the latched request and the counter all reset to 0. A write in flight is abandoned.

## Timing
- Reset values: all outputs 0.
- Stalled cycles per access = `WAIT_CYCLES` + 2 when `sram_ready_i` is already high. Each low-ready cycle after the wait count adds one cycle.
- `WAIT_CYCLES` = 0: IDLE → ACCESS → DONE, 2 stall cycles.
- Read data appears on `rdata_o` in the DONE cycle, registered, and stays stable until the next read completes.
- Back-to-back requests: the request after DONE sees IDLE and asserts `stall_o` in the same cycle.

## Configuration
- `DMEM_TIMEOUT_EN` defined: a timeout counter runs in ACCESS. When it reaches `TIMEOUT_CYCLES` without completion: `err_o` pulses for 1 cycle, a read loads `rdata_o` = 32'h0000_0000, and the state goes to DONE.
- `DMEM_TIMEOUT_EN` not defined: no timeout counter, `err_o` is tied to 0, and ACCESS waits indefinitely for `sram_ready_i`.

## Structure
- `defines.v`: `ADDR_WIDTH`, `DATA_WIDTH`, `ZERO`, `CHIP_ENABLE`/`CHIP_DISABLE`, `WRITE_ENABLE`/`WRITE_DISABLE`, and the new state encodings `DMEM_IDLE` = 2'd0, `DMEM_ACCESS` = 2'd1, `DMEM_DONE` = 2'd2.
- One sub-module, `dmem_wait_cnt`: saturating up-counter with clear. It is instantiated for the wait count and, under the macro, for the timeout count.

## Test plan
- `WAIT_CYCLES` = 1, ready tied high; read 0x100, SRAM returns 0xA5A5_1234 → `stall_o` high for 3 cycles, `rdata_o` = 0xA5A5_1234 in DONE, `sram_oe_o` high for 2 cycles.
- Write 0x104 with 0x1122_3344, `WAIT_CYCLES` = 0 → `sram_we_o` high for exactly 1 cycle, `sram_wdata_o` = 0x1122_3344, `sram_addr_o` = 0x104, `rdata_o` unchanged.
- Unaligned `addr_i` = 0x107 → `sram_addr_o` = 0x104.
- `sram_ready_i` held low for 4 extra cycles → stall lengthens by exactly 4; data is captured only on the ready cycle.
- `rst_i` pulsed in the second ACCESS cycle → next cycle IDLE, all strobes 0, `stall_o` follows `ce_i`.
- `DMEM_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, ready never high → `err_o` pulses once, `rdata_o` = 0, `stall_o` drops in DONE.
